// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined floating-point multiplier.
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  // Canonical quiet NaN {0, all-ones exponent, 1000...}, returned in the low bits.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] r;
    r = ((128'd1 << exp_w) - 128'd1) << man_w;
    r = r | (128'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier: subnormals (exp=0) fold into ZERO so they flush downstream.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_frac,
  output logic [1:0]       o_class
);

  fp_class_e w_cls;

  always_comb begin
    w_cls = FP_NORM;
    if (i_exp == '0)
      w_cls = FP_ZERO;
    else if (&i_exp)
      w_cls = (i_frac == '0) ? FP_INF : FP_NAN;
  end

  assign o_class = w_cls;

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage FP multiplier (unpack / normalize+round / special-select+pack) with global stall.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_res,
  output logic [3:0]           out_flags
);

  localparam int W      = EXP_W + MAN_W + 1;
  localparam int PW     = 2 * (MAN_W + 1);
  localparam int EW     = EXP_W + 2;
  localparam int STAGES = 3;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS_E   = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_E   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO_E  = '0;
  localparam logic [127:0]         QNAN_ALL = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN     = QNAN_ALL[W-1:0];

  logic              w_adv;
  logic [STAGES:1]   r_vld_pipe;

  // S1: unpack / classify
  logic [1:0]        w_cls_a_raw, w_cls_b_raw;
  logic signed [EW-1:0] w_e1;
  logic [PW-1:0]     w_prod;
  logic              r1_sign;
  fp_class_e         r1_cls_a, r1_cls_b;
  logic signed [EW-1:0] r1_e;
  logic [PW-1:0]     r1_prod;

  // S2: normalize / round
  logic [PW-1:0]     w_norm;
  logic signed [EW-1:0] w_e2, w_e_f;
  logic [MAN_W-1:0]  w_frac, w_frac_f;
  logic              w_guard, w_sticky;
  logic              r2_sign, r2_inexact;
  fp_class_e         r2_cls_a, r2_cls_b;
  logic signed [EW-1:0] r2_e;
  logic [MAN_W-1:0]  r2_frac;

  // S3: special select / pack
  logic              w_any_nan, w_any_inf, w_any_zero;
  logic [W-1:0]      w_res;
  logic [3:0]        w_flags;
  logic [W-1:0]      r_res;
  logic [3:0]        r_flags;

  assign w_adv     = !r_vld_pipe[STAGES] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[STAGES];
  assign out_res   = r_res;
  assign out_flags = r_flags;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .i_exp(in_a[W-2 -: EXP_W]), .i_frac(in_a[MAN_W-1:0]), .o_class(w_cls_a_raw));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .i_exp(in_b[W-2 -: EXP_W]), .i_frac(in_b[MAN_W-1:0]), .o_class(w_cls_b_raw));

  assign w_e1 = $signed({2'b00, in_a[W-2 -: EXP_W]}) + $signed({2'b00, in_b[W-2 -: EXP_W]}) - BIAS_E;
  assign w_prod = PW'({1'b1, in_a[MAN_W-1:0]}) * PW'({1'b1, in_b[MAN_W-1:0]});

  // Pre-shift so the leading one always sits at PW-1; the vacated LSB is zero.
  assign w_norm   = r1_prod[PW-1] ? r1_prod : {r1_prod[PW-2:0], 1'b0};
  assign w_e2     = r1_e + $signed({{(EW-1){1'b0}}, r1_prod[PW-1]});
  assign w_frac   = w_norm[PW-2 -: MAN_W];
  assign w_guard  = w_norm[PW-2-MAN_W];
  assign w_sticky = |w_norm[PW-3-MAN_W:0];

`ifdef FP_MUL_RNE_EN
  logic             w_rup;
  logic [MAN_W:0]   w_rnd;
  assign w_rup    = w_guard & (w_sticky | w_frac[0]);
  assign w_rnd    = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_rup};
  // A carry out means the fraction wrapped to zero; bump the exponent.
  assign w_frac_f = w_rnd[MAN_W-1:0];
  assign w_e_f    = w_e2 + $signed({{(EW-1){1'b0}}, w_rnd[MAN_W]});
`else
  assign w_frac_f = w_frac;
  assign w_e_f    = w_e2;
`endif

  always_comb begin
    w_any_nan  = (r2_cls_a == FP_NAN)  || (r2_cls_b == FP_NAN);
    w_any_inf  = (r2_cls_a == FP_INF)  || (r2_cls_b == FP_INF);
    w_any_zero = (r2_cls_a == FP_ZERO) || (r2_cls_b == FP_ZERO);
    w_res      = {r2_sign, r2_e[EXP_W-1:0], r2_frac};
    w_flags    = '0;
    if (w_any_nan || (w_any_inf && w_any_zero)) begin
      w_res = QNAN;
      w_flags[FLG_INVALID] = 1'b1;
    end else if (w_any_inf) begin
      w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_any_zero) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
    end else if (r2_e >= EMAX_E) begin
      w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags[FLG_OVERFLOW] = 1'b1;
      w_flags[FLG_INEXACT]  = 1'b1;
    end else if (r2_e <= EZERO_E) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
      w_flags[FLG_UNDERFLOW] = 1'b1;
      w_flags[FLG_INEXACT]   = 1'b1;
    end else begin
      w_flags[FLG_INEXACT] = r2_inexact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r1_sign    <= 1'b0;
      r1_cls_a   <= FP_ZERO;
      r1_cls_b   <= FP_ZERO;
      r1_e       <= '0;
      r1_prod    <= '0;
      r2_sign    <= 1'b0;
      r2_cls_a   <= FP_ZERO;
      r2_cls_b   <= FP_ZERO;
      r2_e       <= '0;
      r2_frac    <= '0;
      r2_inexact <= 1'b0;
      r_res      <= '0;
      r_flags    <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      r1_sign    <= in_a[W-1] ^ in_b[W-1];
      r1_cls_a   <= fp_class_e'(w_cls_a_raw);
      r1_cls_b   <= fp_class_e'(w_cls_b_raw);
      r1_e       <= w_e1;
      r1_prod    <= w_prod;
      r2_sign    <= r1_sign;
      r2_cls_a   <= r1_cls_a;
      r2_cls_b   <= r1_cls_b;
      r2_e       <= w_e_f;
      r2_frac    <= w_frac_f;
      r2_inexact <= w_guard | w_sticky;
      // Bubbles leave the output as zero so flags never leak without out_valid.
      r_res      <= r_vld_pipe[2] ? w_res : '0;
      r_flags    <= r_vld_pipe[2] ? w_flags : '0;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (binary32 defaults); honours FP_MUL_RNE_EN.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  out_flags;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  int ip, op, cyc;
  logic        hold;
  logic [31:0] held;
  logic [31:0] exp_rnd;

  logic [31:0] sa [8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000,
                          32'hC0000000, 32'h3F000000, 32'h40800000, 32'h3FA00000};
  logic [31:0] sb [8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h3F000000,
                          32'h40400000, 32'h3F000000, 32'h40800000, 32'h40000000};
  logic [31:0] sr [8] = '{32'h3F800000, 32'h40800000, 32'h40100000, 32'h3FC00000,
                          32'hC0C00000, 32'h3E800000, 32'h41800000, 32'h40200000};

  fp_mul_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One isolated operation: checks acceptance, 3-cycle latency, result and flags.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, ".lat2"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".res"}, out_res, r);
    chk({tag, ".flags"}, 32'(out_flags), 32'(f));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #2;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_res", out_res, 0);
    chk("rst.out_flags", 32'(out_flags), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifdef FP_MUL_RNE_EN
    exp_rnd = 32'h40400002;
`else
    exp_rnd = 32'h40400001;
`endif
    run_one("mul1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_one("round",    32'h3F800001, 32'h40400000, exp_rnd,      4'b0001);
    run_one("ovf",      32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    run_one("unf",      32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    run_one("infxzero", 32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000);
    run_one("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run_one("negzero",  32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    run_one("infxnorm", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);

    // Stream with random back-pressure.
    ip = 0; op = 0; cyc = 0; hold = 1'b0; held = '0;
    while (op < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("strm.hold_vld", 32'(out_valid), 1);
        chk("strm.hold_res", out_res, held);
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (ip < 8);
      if (ip < 8) begin
        in_a = sa[ip]; in_b = sb[ip];
      end
      #1;
      chk("strm.in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        chk($sformatf("strm.res%0d", op), out_res, sr[op]);
        chk($sformatf("strm.flags%0d", op), 32'(out_flags), 0);
        op++;
      end
      hold = out_valid && !out_ready;
      held = out_res;
      if (in_valid && in_ready) ip++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("strm.count", op, 8);
    repeat (4) begin
      @(negedge clk);
      chk("strm.no_dup", 32'(out_valid), 0);
    end

    // Reset with two results in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
    @(negedge clk);
    in_a = 32'h40000000; in_b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstfly.pre_valid", 32'(out_valid), 1);
    chk("rstfly.pre_res", out_res, 32'h3F800000);
    rst = 1'b1;
    #1;
    chk("rstfly.out_valid", 32'(out_valid), 0);
    chk("rstfly.out_res", out_res, 0);
    chk("rstfly.out_flags", 32'(out_flags), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rstfly.no_stale", 32'(out_valid), 0);
    end
    run_one("post_rst", 32'h3FA00000, 32'h40000000, 32'h40200000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
